ps2_key_encoder: RTL and testbench



---
 rtl/ps2_key_encoder.sv | 155 +++++++++++++++
 tb/tb_ps2_key_encoder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_encoder.sv
// PS/2 keyboard receiver and scancode decoder that produces the 11-bit toggle-strobe ps2_key word.
// Optional build macro PS2_TYPEMATIC_FILTER_EN suppresses repeated makes of keys already held.
module ps2_key_encoder #(
  parameter int CLK_HZ     = 12000000,
  parameter int TIMEOUT_US = 2000,
  parameter int FILT_LEN   = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ps2_clk_in,
  input  logic        ps2_dat_in,
  output logic [10:0] ps2_key,
  output logic        rx_err,
  output logic        pause_key
);

  localparam int TO_CYC = (CLK_HZ / 1000000) * TIMEOUT_US;
  localparam int TW     = $clog2(TO_CYC + 1);
  localparam int FW     = $clog2(FILT_LEN + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    dat_sync;
  logic          filt_clk;
  logic [FW-1:0] filt_cnt;
  logic          strobe;

  state_t        state;
  logic [2:0]    bitcnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tcnt;
  logic          ext;
  logic          brk;
  logic [2:0]    skip;
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [511:0]  pressed_tab;
`endif

  logic bit_in;
  logic frame_ok;
  logic timeout;
  logic is_junk;

  assign bit_in   = dat_sync[1];
  assign frame_ok = bit_in && (^{shreg, par});
  assign timeout  = (state != IDLE) && !strobe && (tcnt == TW'(TO_CYC - 1));
  assign is_junk  = (shreg == 8'hFA) || (shreg == 8'hAA) || (shreg == 8'hEE) ||
                    (shreg == 8'hFE) || (shreg == 8'h00) || (shreg == 8'hFF);

  // Idle-high line: synchronizers and filter start at 1 so reset never fakes a falling edge.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      strobe   <= 1'b0;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk_in};
      dat_sync <= {dat_sync[0], ps2_dat_in};
      strobe   <= 1'b0;
      if (clk_sync[1] == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
        filt_clk <= clk_sync[1];
        filt_cnt <= '0;
        strobe   <= filt_clk;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      tcnt      <= '0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      skip      <= '0;
      ps2_key   <= 11'h000;
      rx_err    <= 1'b0;
      pause_key <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      pressed_tab <= '0;
`endif
    end else begin
      rx_err    <= 1'b0;
      pause_key <= 1'b0;
      if (strobe || state == IDLE) tcnt <= '0;
      else                         tcnt <= tcnt + 1'b1;

      if (timeout) begin
        state  <= IDLE;
        rx_err <= 1'b1;
        ext    <= 1'b0;
        brk    <= 1'b0;
      end else if (strobe) begin
        case (state)
          IDLE: begin
            if (!bit_in) begin
              state  <= SHIFT;
              bitcnt <= '0;
            end
          end
          SHIFT: begin
            shreg  <= {bit_in, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= bit_in;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (!frame_ok) begin
              rx_err <= 1'b1;
              ext    <= 1'b0;
              brk    <= 1'b0;
              skip   <= '0;
            end else if (skip != 3'd0) begin
              // Remaining Pause bytes are swallowed without interpretation.
              skip <= skip - 1'b1;
              if (skip == 3'd1) pause_key <= 1'b1;
            end else if (shreg == 8'hE1) begin
              skip <= 3'd7;
            end else if (shreg == 8'hE0) begin
              ext <= 1'b1;
            end else if (shreg == 8'hF0) begin
              brk <= 1'b1;
            end else if (!(is_junk && !ext && !brk)) begin
              ext <= 1'b0;
              brk <= 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
              pressed_tab[{ext, shreg}] <= !brk;
              if (brk || !pressed_tab[{ext, shreg}])
                ps2_key <= {~ps2_key[10], ~brk, ext, shreg};
`else
              ps2_key <= {~ps2_key[10], ~brk, ext, shreg};
`endif
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Randomized and directed bench for ps2_key_encoder with a byte-level reference model and event scoreboard.
module tb_ps2_key_encoder;

  localparam int CLK_HZ     = 1000000;
  localparam int TIMEOUT_US = 300;
  localparam int FILT_LEN   = 4;
  localparam int TO_CYC     = (CLK_HZ / 1000000) * TIMEOUT_US;
  localparam int HALF       = 12;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [10:0] ps2_key;
  logic        rx_err;
  logic        pause_key;

  always #5 clk = ~clk;

  ps2_key_encoder #(.CLK_HZ(CLK_HZ), .TIMEOUT_US(TIMEOUT_US), .FILT_LEN(FILT_LEN)) dut (
    .clk_sys(clk), .reset(reset), .ps2_clk_in(ps2_clk), .ps2_dat_in(ps2_dat),
    .ps2_key(ps2_key), .rx_err(rx_err), .pause_key(pause_key)
  );

  int tests = 0;
  int failed = 0;

  // Scoreboard entries: [12:11] kind (1 key, 2 error, 3 pause), [10:0] key word.
  logic [12:0] exp_q[$];

  // reference model state
  logic [10:0]  m_key;
  bit           m_ext, m_brk;
  int           m_skip;
  bit [511:0]   m_pressed;

  task automatic model_reset();
    m_key = 11'h000; m_ext = 0; m_brk = 0; m_skip = 0; m_pressed = '0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good);
    bit emit;
    logic [8:0] idx;
    if (!good) begin
      exp_q.push_back({2'd2, 11'h000});
      m_ext = 0; m_brk = 0; m_skip = 0;
      return;
    end
    if (m_skip != 0) begin
      m_skip--;
      if (m_skip == 0) exp_q.push_back({2'd3, 11'h000});
      return;
    end
    if (b == 8'hE1) begin m_skip = 7; return; end
    if (b == 8'hE0) begin m_ext = 1; return; end
    if (b == 8'hF0) begin m_brk = 1; return; end
    if (!m_ext && !m_brk && (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) return;
    emit = 1;
    idx = {m_ext, b};
`ifdef PS2_TYPEMATIC_FILTER_EN
    if (!m_brk && m_pressed[idx]) emit = 0;
    m_pressed[idx] = !m_brk;
`endif
    if (emit) begin
      m_key = {~m_key[10], ~m_brk, m_ext, b};
      exp_q.push_back({2'd1, m_key});
    end
    m_ext = 0; m_brk = 0;
  endtask

  // monitor: every observed output event is popped against the queue
  logic [10:0] prev_key;

  task automatic check_event(input string name, input logic [12:0] got);
    logic [12:0] exp;
    tests++;
    if (exp_q.size() == 0) begin
      failed++;
      $display("FAIL %s: unexpected event kind=%0d key=%h, none expected", name, got[12:11], got[10:0]);
    end else begin
      exp = exp_q.pop_front();
      if (exp !== got) begin
        failed++;
        $display("FAIL %s: got kind=%0d key=%h, expected kind=%0d key=%h",
                 name, got[12:11], got[10:0], exp[12:11], exp[10:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_key = ps2_key;
    end else begin
      if (ps2_key !== prev_key) check_event("key", {2'd1, ps2_key});
      if (rx_err !== 1'b0) check_event("rx_err", {2'd2, 11'h000});
      if (pause_key !== 1'b0) check_event("pause", {2'd3, 11'h000});
      prev_key = ps2_key;
    end
  end

  // driver tasks
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic drain(input string name);
    wait_cyc(30);
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain %s: %0d expected events not seen, 0 required", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    model_byte(b, !(bad_par || bad_stop));
    send_bits(bits, 11);
    drain($sformatf("byte %h", b));
  endtask

  task automatic send_good(input logic [7:0] b);
    send_byte(b, 1'b0, 1'b0);
  endtask

  task automatic check_val(input string name, input logic [10:0] got, input logic [10:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "watchdog");
  end

  logic [7:0] pick;
  logic [7:0] pause_seq [8];

  initial begin
    model_reset();
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(2);
    @(negedge clk);
    check_val("reset ps2_key", ps2_key, 11'h000);
    check_val("reset rx_err", {10'd0, rx_err}, 11'h000);
    check_val("reset pause_key", {10'd0, pause_key}, 11'h000);

    // directed: make/break, extended, prefix orders
    send_good(8'h29);
    check_val("space make", ps2_key, 11'h629);
    send_good(8'hF0); send_good(8'h29);
    check_val("space break", ps2_key, 11'h029);
    send_good(8'hE0); send_good(8'h75);
    send_good(8'hE0); send_good(8'hF0); send_good(8'h75);
    send_good(8'hF0); send_good(8'hE0); send_good(8'h6B);

    // bad parity, bad stop, then recovery
    send_byte(8'h1C, 1'b1, 1'b0);
    send_byte(8'h1C, 1'b0, 1'b1);
    send_good(8'h1C);
    send_good(8'hF0); send_good(8'h1C);

    // timeout mid-frame
    model_byte(8'h00, 1'b0);
    send_bits(11'h7FE, 5);
    wait_cyc(TO_CYC + 50);
    drain("timeout");
    send_good(8'h1C);
    send_good(8'hF0); send_good(8'h1C);

    // junk bytes discarded when unprefixed
    send_good(8'hFA); send_good(8'hAA); send_good(8'h00);

    // Pause sequence
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    for (int i = 0; i < 8; i++) send_good(pause_seq[i]);

    // typematic repeats
    send_good(8'h29); send_good(8'h29); send_good(8'h29);
    send_good(8'hF0); send_good(8'h29);
    send_good(8'h29);
    send_good(8'hF0); send_good(8'h29);

    // short glitch on the clock line must be filtered out
    ps2_clk = 1'b0; wait_cyc(2); ps2_clk = 1'b1;
    wait_cyc(20);
    send_good(8'h1B);

    // reset mid-frame aborts silently
    send_bits(11'h7FE, 5);
    reset = 1'b1;
    wait_cyc(3);
    reset = 1'b0;
    model_reset();
    wait_cyc(TO_CYC + 50);
    drain("mid-frame reset");
    @(negedge clk);
    check_val("key after reset", ps2_key, 11'h000);
    send_good(8'h29);

    // randomized traffic
    for (int n = 0; n < 70; n++) begin
      case ($urandom_range(0, 9))
        0: pick = 8'hE0;
        1: pick = 8'hF0;
        2: pick = 8'hFA;
        3: pick = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h00;
        4, 5: pick = 8'h1C;
        default: pick = 8'($urandom_range(0, 255));
      endcase
      if ($urandom_range(0, 9) == 0) send_byte(pick, $urandom_range(0, 1) == 1, 1'b0);
      else if ($urandom_range(0, 19) == 0) send_byte(pick, 1'b0, 1'b1);
      else send_good(pick);
    end

    wait_cyc(50);
    drain("final");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
